// File: rtl/led_bar_pkg.sv
// Shared types and constants for the LED bar-graph sequencer.
package led_bar_pkg;

    typedef enum logic [1:0] {CLEAR, ACQ, PUBLISH} state_t;

    // 10 Hz refresh with a 100 MHz clk
    localparam int DEFAULT_REFRESH_CYC = 10_000_000;

    function automatic int tick_cnt_w(input int refresh_cyc);
        return (refresh_cyc > 1) ? $clog2(refresh_cyc) : 1;
    endfunction

endpackage

// File: rtl/led_bar_ctrl_refresh_tick_gen.sv
// Free-running refresh counter; emits a one-cycle tick on its last count.
module refresh_tick_gen
    import led_bar_pkg::*;
#(
    parameter int REFRESH_CYC = DEFAULT_REFRESH_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = tick_cnt_w(REFRESH_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_bar_ctrl.sv
// Source select, refresh throttling, peak-hold and stale blanking for the LED bar driver.
//
// state   | meaning
// CLEAR   | one-cycle bar clear, latch source select, drop pending sample/peak
// ACQ     | accept samples until the refresh tick
// PUBLISH | one-cycle update strobe carrying the captured value
module led_bar_ctrl
    import led_bar_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int N_SRC       = 3,
    parameter int REFRESH_CYC = DEFAULT_REFRESH_CYC,
    parameter int HOLD_TICKS  = 10,
    parameter int STALE_TICKS = 5,
    localparam int SEL_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC*DATA_W-1:0] src_data_i,
    input  logic [N_SRC-1:0]        src_valid_i,
    output logic [N_SRC-1:0]        src_ready_o,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    hold_en_i,
    output logic [DATA_W-1:0]       bar_din_o,
    output logic                    bar_update_o,
    output logic                    bar_clr_o,
    output logic                    stale_o
);

    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int STALE_W = $clog2(STALE_TICKS + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_TICKS);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_TICKS);

    state_t state, state_nxt;

    logic [SEL_W-1:0]   sel_eff, sel_q;
    logic [DATA_W-1:0]  sample_q, sample_nxt, src_sel_data, bar_din_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [STALE_W-1:0] stale_cnt_q;
    logic               have_sample_q, peak_held_q, stale_q, clr_pulse_q;
    logic               tick, xfer, sel_change, publish_go, clr_fsm;

    refresh_tick_gen #(.REFRESH_CYC(REFRESH_CYC)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == CLEAR),
        .tick  (tick)
    );

    assign sel_eff      = (32'(sel_i) < N_SRC) ? sel_i : '0;
    assign sel_change   = (sel_eff != sel_q);
    assign src_sel_data = src_data_i[sel_q*DATA_W +: DATA_W];
    assign xfer         = (state == ACQ) && src_valid_i[sel_q];

    always_comb begin
        sample_nxt = sample_q;
        if (xfer) begin
            if (hold_en_i && (sample_q > src_sel_data)) begin
                sample_nxt = sample_q;
            end else begin
                sample_nxt = src_sel_data;
            end
        end
    end

    // A retained peak is republished once after hold is switched off.
    assign publish_go = tick && (have_sample_q || xfer || (peak_held_q && !hold_en_i));

    always_comb begin
        state_nxt    = state;
        src_ready_o  = '0;
        bar_update_o = 1'b0;
        clr_fsm      = 1'b0;
        case (state)
            CLEAR: begin
                clr_fsm   = 1'b1;
                state_nxt = ACQ;
            end
            ACQ: begin
                src_ready_o = '1;
                if (sel_change) begin
                    state_nxt = CLEAR;
                end else if (publish_go) begin
                    state_nxt = PUBLISH;
                end
            end
            PUBLISH: begin
                bar_update_o = 1'b1;
                state_nxt    = sel_change ? CLEAR : ACQ;
            end
            default: state_nxt = CLEAR;
        endcase
        // Reset owns the cycle: no strobe or ready while rst_n is low.
        if (!rst_n) begin
            src_ready_o  = '0;
            bar_update_o = 1'b0;
            clr_fsm      = 1'b0;
        end
    end

    assign bar_clr_o = rst_n && (clr_fsm || clr_pulse_q);
    assign bar_din_o = bar_din_q;
    assign stale_o   = stale_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= CLEAR;
            sel_q         <= '0;
            sample_q      <= '0;
            bar_din_q     <= '0;
            hold_cnt_q    <= '0;
            stale_cnt_q   <= '0;
            have_sample_q <= 1'b0;
            peak_held_q   <= 1'b0;
            stale_q       <= 1'b0;
            clr_pulse_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_pulse_q <= 1'b0;
            if (!hold_en_i) begin
                hold_cnt_q <= '0;
            end
            case (state)
                CLEAR: begin
                    sel_q         <= sel_eff;
                    sample_q      <= '0;
                    have_sample_q <= 1'b0;
                    peak_held_q   <= 1'b0;
                    hold_cnt_q    <= '0;
                end
                ACQ: begin
                    if (!sel_change) begin
                        sample_q <= sample_nxt;
                        if (xfer) begin
                            have_sample_q <= 1'b1;
                        end
                        // Strobe and data leave together so the driver latches a settled value.
                        if (publish_go) begin
                            bar_din_q <= sample_nxt;
                        end else if (tick && (stale_cnt_q != STALE_MAX)) begin
                            stale_cnt_q <= stale_cnt_q + 1'b1;
                            if (stale_cnt_q == STALE_MAX - 1'b1) begin
                                stale_q     <= 1'b1;
                                clr_pulse_q <= 1'b1;
                            end
                        end
                    end
                end
                PUBLISH: begin
                    have_sample_q <= 1'b0;
                    stale_cnt_q   <= '0;
                    stale_q       <= 1'b0;
                    if (!hold_en_i) begin
                        sample_q    <= '0;
                        peak_held_q <= 1'b0;
                    end else if (hold_cnt_q == HOLD_MAX - 1'b1) begin
                        sample_q    <= '0;
                        hold_cnt_q  <= '0;
                        peak_held_q <= 1'b0;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + 1'b1;
                        peak_held_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_bar_ctrl.sv
// Directed scenarios plus a randomized run against a behavioural model of the bar sequencer.
module tb_led_bar_ctrl;

    localparam int DW = 12;
    localparam int NS = 3;
    localparam int RC = 8;
    localparam int HT = 2;
    localparam int ST = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0]  src_valid = '0;
    logic [NS-1:0]  src_ready;
    logic [1:0]     sel = '0;
    logic           hold_en = 1'b0;
    logic [DW-1:0]  bar_din;
    logic           bar_update, bar_clr, stale;

    int checks = 0;
    int errors = 0;

    led_bar_ctrl #(
        .DATA_W(DW), .N_SRC(NS), .REFRESH_CYC(RC), .HOLD_TICKS(HT), .STALE_TICKS(ST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_data_i   (src_data),
        .src_valid_i  (src_valid),
        .src_ready_o  (src_ready),
        .sel_i        (sel),
        .hold_en_i    (hold_en),
        .bar_din_o    (bar_din),
        .bar_update_o (bar_update),
        .bar_clr_o    (bar_clr),
        .stale_o      (stale)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = clearing, 1 = acquiring, 2 = publishing
    int            m_mode = 0, m_cnt = 0, m_sel = 0, m_nsamp = 0, m_holds = 0, m_missed = 0;
    logic [DW-1:0] m_val = '0, m_din = '0;
    bit            m_retained = 0, m_stale = 0, m_pulse = 0;

    logic          exp_upd, exp_clr, exp_stale;
    logic [DW-1:0] exp_din;
    logic [NS-1:0] exp_rdy;

    int            n_upd = 0, n_clr = 0;
    logic [DW-1:0] last_din = '0;
    logic [1:0]    cur_sel = 0;
    logic          cur_hold = 0;

    task automatic model_step(input logic r, input logic [1:0] s, input logic [NS-1:0] v,
                              input logic [NS*DW-1:0] d, input logic h);
        int se;
        bit tk;
        logic [DW-1:0] dd;
        se = (s < NS) ? int'(s) : 0;
        if (!r) begin
            m_mode = 0; m_cnt = 0; m_sel = 0; m_val = '0; m_nsamp = 0; m_retained = 0;
            m_holds = 0; m_missed = 0; m_stale = 0; m_pulse = 0; m_din = '0;
            return;
        end
        tk = (m_mode != 0) && (m_cnt == RC - 1);
        m_cnt = (m_mode == 0) ? 0 : (m_cnt + 1) % RC;
        m_pulse = 0;
        if (!h) m_holds = 0;
        case (m_mode)
            0: begin
                m_sel = se; m_val = '0; m_nsamp = 0; m_retained = 0; m_holds = 0; m_mode = 1;
            end
            1: begin
                if (se != m_sel) begin
                    m_mode = 0;
                end else begin
                    if (v[m_sel]) begin
                        dd = d[m_sel*DW +: DW];
                        m_val = (h && m_val > dd) ? m_val : dd;
                        m_nsamp++;
                    end
                    if (tk) begin
                        if (m_nsamp > 0 || (m_retained && !h)) begin
                            m_din = m_val;
                            m_mode = 2;
                        end else if (m_missed < ST) begin
                            m_missed++;
                            if (m_missed == ST) begin
                                m_stale = 1; m_pulse = 1;
                            end
                        end
                    end
                end
            end
            default: begin
                m_nsamp = 0; m_missed = 0; m_stale = 0;
                if (!h) begin
                    m_val = '0; m_retained = 0;
                end else if (m_holds + 1 == HT) begin
                    m_val = '0; m_holds = 0; m_retained = 0;
                end else begin
                    m_holds++; m_retained = 1;
                end
                m_mode = (se != m_sel) ? 0 : 1;
            end
        endcase
    endtask

    task automatic cycle(input logic r, input logic [1:0] s, input logic [NS-1:0] v,
                         input logic [NS*DW-1:0] d, input logic h);
        @(negedge clk);
        rst_n = r; sel = s; src_valid = v; src_data = d; hold_en = h;
        #1;
        exp_upd   = r && (m_mode == 2);
        exp_clr   = r && (m_mode == 0 || m_pulse);
        exp_rdy   = (r && m_mode == 1) ? '1 : '0;
        exp_din   = m_din;
        exp_stale = m_stale;
        if (bar_update === 1'b1) begin
            n_upd++;
            last_din = bar_din;
        end
        if (bar_clr === 1'b1) n_clr++;
        model_step(r, s, v, d, h);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, cur_sel, '0, '0, cur_hold);
    endtask

    task automatic send(input int src, input logic [DW-1:0] val);
        logic [NS*DW-1:0] d;
        logic [NS-1:0] v;
        d = '0; v = '0;
        d[src*DW +: DW] = val;
        v[src] = 1'b1;
        cycle(1'b1, cur_sel, v, d, cur_hold);
    endtask

    task automatic do_reset();
        repeat (3) cycle(1'b0, cur_sel, '0, '0, cur_hold);
    endtask

    task automatic wait_update(input int budget, output bit got, output logic [DW-1:0] din);
        got = 0; din = '0;
        for (int i = 0; i < budget && !got; i++) begin
            n_upd = 0;
            idle(1);
            if (n_upd != 0) begin
                got = 1; din = last_din;
            end
        end
    endtask

    task automatic test_reset();
        bit got;
        logic [DW-1:0] din;
        cur_sel = 0; cur_hold = 0;
        cycle(1'b0, 2'd0, '1, {NS{12'hFFF}}, 1'b0);
        cycle(1'b0, 2'd0, '1, {NS{12'hFFF}}, 1'b0);
        checks++;
        if (bar_update !== 1'b0 || bar_clr !== 1'b0 || src_ready !== '0) begin
            errors++;
            $display("FAIL reset_strobes got upd=%b clr=%b rdy=%b exp 0 0 000", bar_update, bar_clr, src_ready);
        end
        checks++;
        if (bar_din !== '0 || stale !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got din=%h stale=%b exp 000 0", bar_din, stale);
        end
        idle(1);
        checks++;
        if (bar_clr !== 1'b1) begin
            errors++;
            $display("FAIL clr_after_reset got %b exp 1", bar_clr);
        end
        idle(1);
        checks++;
        if (src_ready !== 3'b111) begin
            errors++;
            $display("FAIL acq_ready got %b exp 111", src_ready);
        end
        send(0, 12'h100);
        idle(1);
        send(0, 12'h200);
        n_upd = 0;
        idle(10);
        checks++;
        if (n_upd != 1 || last_din !== 12'h200) begin
            errors++;
            $display("FAIL first_publish got n=%0d din=%h exp n=1 din=200", n_upd, last_din);
        end
        wait_update(2, got, din);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL no_repeat_publish got update din=%h exp none", din);
        end
    endtask

    task automatic test_peak_hold();
        logic [DW-1:0] w1[2] = '{12'h300, 12'h100};
        logic [DW-1:0] exp_v[3] = '{12'h300, 12'h300, 12'h020};
        logic [DW-1:0] later[2] = '{12'h050, 12'h020};
        bit got;
        logic [DW-1:0] din;
        cur_sel = 0; cur_hold = 1;
        do_reset();
        idle(1);
        send(0, w1[0]);
        send(0, w1[1]);
        for (int k = 0; k < 3; k++) begin
            wait_update(20, got, din);
            checks++;
            if (!got || din !== exp_v[k]) begin
                errors++;
                $display("FAIL peak_hold_%0d got found=%0d din=%h exp %h", k, got, din, exp_v[k]);
            end
            if (k < 2) send(0, later[k]);
        end
        cur_hold = 0;
    endtask

    task automatic test_src_change();
        int first;
        cur_sel = 0; cur_hold = 0;
        do_reset();
        idle(2);
        send(0, 12'h7FF);
        cur_sel = 1;
        idle(1);
        checks++;
        if (bar_clr !== 1'b0) begin
            errors++;
            $display("FAIL sel_detect_cycle got clr=%b exp 0", bar_clr);
        end
        idle(1);
        checks++;
        if (bar_clr !== 1'b1) begin
            errors++;
            $display("FAIL clr_on_sel_change got %b exp 1", bar_clr);
        end
        send(1, 12'h123);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            n_upd = 0;
            idle(1);
            if (n_upd != 0 && first == 0) first = k;
        end
        checks++;
        if (first != RC || last_din !== 12'h123) begin
            errors++;
            $display("FAIL tick_restart got at=%0d din=%h exp at=%0d din=123", first, last_din, RC);
        end
    endtask

    task automatic test_stale();
        int clr_at, stale_at;
        bit got;
        logic [DW-1:0] din;
        cur_sel = 0; cur_hold = 0;
        do_reset();
        idle(1);
        clr_at = 0; stale_at = 0; n_clr = 0;
        for (int c = 1; c <= 40; c++) begin
            idle(1);
            if (bar_clr === 1'b1 && clr_at == 0) clr_at = c;
            if (stale === 1'b1 && stale_at == 0) stale_at = c;
        end
        checks++;
        if (clr_at != 3 * RC + 1 || stale_at != 3 * RC + 1 || n_clr != 1) begin
            errors++;
            $display("FAIL stale_blank got clr_at=%0d stale_at=%0d n=%0d exp %0d %0d 1",
                     clr_at, stale_at, n_clr, 3 * RC + 1, 3 * RC + 1);
        end
        checks++;
        if (stale !== 1'b1) begin
            errors++;
            $display("FAIL stale_held got %b exp 1", stale);
        end
        send(0, 12'h010);
        wait_update(20, got, din);
        checks++;
        if (!got || din !== 12'h010) begin
            errors++;
            $display("FAIL stale_recover got found=%0d din=%h exp 010", got, din);
        end
        idle(1);
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL stale_cleared got %b exp 0", stale);
        end
    endtask

    task automatic test_same_cycle_tick();
        cur_sel = 0; cur_hold = 0;
        do_reset();
        idle(RC);
        send(0, 12'hABC);
        checks++;
        if (bar_update !== 1'b0) begin
            errors++;
            $display("FAIL tick_cycle_no_strobe got %b exp 0", bar_update);
        end
        idle(1);
        checks++;
        if (bar_update !== 1'b1 || bar_din !== 12'hABC || bar_clr !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_tick got upd=%b din=%h clr=%b exp 1 abc 0", bar_update, bar_din, bar_clr);
        end
    endtask

    task automatic test_unselected();
        logic [NS*DW-1:0] d;
        logic [NS-1:0] v;
        int bad_rdy, bad_din, pubs;
        cur_sel = 0; cur_hold = 0;
        do_reset();
        bad_rdy = 0; bad_din = 0; pubs = 0;
        for (int c = 0; c < 50; c++) begin
            d = '0;
            d[2*DW +: DW] = 12'hEEE;
            d[DW-1:0] = 12'($urandom_range(0, 12'h7FF));
            v = 3'b100;
            v[0] = ($urandom_range(0, 3) == 0);
            cycle(1'b1, cur_sel, v, d, cur_hold);
            if (src_ready[2] !== exp_rdy[2]) bad_rdy++;
            if (bar_din === 12'hEEE) bad_din++;
            if (bar_update === 1'b1) pubs++;
        end
        checks++;
        if (bad_rdy != 0 || bad_din != 0 || pubs == 0) begin
            errors++;
            $display("FAIL unselected_src got bad_rdy=%0d eee_seen=%0d pubs=%0d exp 0 0 >0", bad_rdy, bad_din, pubs);
        end
    endtask

    task automatic test_random();
        logic r;
        logic [NS-1:0] v;
        logic [NS*DW-1:0] d;
        int vp;
        cur_sel = 0; cur_hold = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) cur_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) cur_hold = !cur_hold;
            vp = (i < 400) ? 5 : 30;
            for (int k = 0; k < NS; k++) begin
                v[k] = ($urandom_range(0, vp - 1) == 0);
                d[k*DW +: DW] = 12'($urandom);
            end
            cycle(r, cur_sel, v, d, cur_hold);
            checks++;
            if (bar_update !== exp_upd) begin
                errors++;
                $display("FAIL rand_update cyc %0d got %b exp %b", i, bar_update, exp_upd);
            end
            checks++;
            if (bar_clr !== exp_clr) begin
                errors++;
                $display("FAIL rand_clr cyc %0d got %b exp %b", i, bar_clr, exp_clr);
            end
            checks++;
            if (bar_din !== exp_din) begin
                errors++;
                $display("FAIL rand_din cyc %0d got %h exp %h", i, bar_din, exp_din);
            end
            checks++;
            if (stale !== exp_stale) begin
                errors++;
                $display("FAIL rand_stale cyc %0d got %b exp %b", i, stale, exp_stale);
            end
            checks++;
            if (src_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready cyc %0d got %b exp %b", i, src_ready, exp_rdy);
            end
            checks++;
            if (bar_update === 1'b1 && bar_clr === 1'b1) begin
                errors++;
                $display("FAIL rand_excl cyc %0d got upd=1 clr=1 exp not both", i);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_peak_hold();
        test_src_change();
        test_stale();
        test_same_cycle_tick();
        test_unselected();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
